seg_dynamic_ctrl: RTL and testbench

Display controller for the 6-digit 7-segment module. It accepts a binary value and converts it to BCD with a sequential double-dabble engine. It applies leading-zero blanking, a minus sign and per-digit decimal points, then time-multiplexes the digits onto sel/seg. It sits between application logic (counters, measurement blocks) and the segment/595 driver pins.

---
 rtl/seg_pkg.sv | 58 +++++
 rtl/bin2bcd_seq.sv | 77 +++++++
 rtl/seg_dynamic_ctrl.sv | 133 +++++++++++++
 tb/tb_seg_dynamic_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the 6-digit 7-segment display controller.
package seg_pkg;

  localparam int DIGIT_NUM    = 6;
  localparam int BIN_W        = 20;
  localparam int BCD_W        = 4 * DIGIT_NUM;
  localparam int SHIFT_CYCLES = BIN_W;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Active-low patterns, bit 7 = dp, bits 6:0 = g..a
  localparam logic [7:0] SEG_CODE [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  localparam logic [BIN_W-1:0] MAX_POS = 20'd999999;
  localparam logic [BIN_W-1:0] MAX_NEG = 20'd99999;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } conv_state_e;

  typedef struct packed {
    logic [BCD_W-1:0]     bcd;
    logic                 neg;
    logic [DIGIT_NUM-1:0] point;
  } disp_t;

  // A negative value loses one digit to the minus sign, so it clamps lower.
  function automatic logic [BIN_W-1:0] sat_value(input logic [BIN_W-1:0] v,
                                                 input logic             neg);
    logic [BIN_W-1:0] lim;
    lim = neg ? MAX_NEG : MAX_POS;
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [7:0] digit_code(input logic [3:0] d);
    logic [7:0] code;
    case (d)
      4'd0:    code = SEG_CODE[0];
      4'd1:    code = SEG_CODE[1];
      4'd2:    code = SEG_CODE[2];
      4'd3:    code = SEG_CODE[3];
      4'd4:    code = SEG_CODE[4];
      4'd5:    code = SEG_CODE[5];
      4'd6:    code = SEG_CODE[6];
      4'd7:    code = SEG_CODE[7];
      4'd8:    code = SEG_CODE[8];
      4'd9:    code = SEG_CODE[9];
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 20-bit binary to 6 BCD digits in 20 shift cycles.
// done/bcd present the final result combinationally during the last shift cycle.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [4:0] LAST_SHIFT = 5'(SHIFT_CYCLES - 1);

  conv_state_e      state_q;
  logic [4:0]       cnt_q;
  logic             busy_q;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BIN_W-1:0] bin_d;
  logic [BCD_W-1:0] adj_d;
  logic [BCD_W-1:0] bcd_d;

  // Add-3 on every nibble >= 5, then shift {bcd,bin} left by one.
  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < DIGIT_NUM; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d = BCD_W'({adj_d, bin_q[BIN_W-1]});
    bin_d = {bin_q[BIN_W-2:0], 1'b0};
  end

  assign done = (state_q == ST_SHIFT) && (cnt_q == LAST_SHIFT);
  assign bcd  = bcd_d;
  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bin_q   <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          if (cnt_q == LAST_SHIFT) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg_dynamic_ctrl.sv
// 6-digit multiplexed 7-segment controller: binary capture, BCD conversion,
// leading-zero blanking with sign/decimal points, and per-digit scan.
module seg_dynamic_ctrl
  import seg_pkg::*;
#(
  parameter logic [15:0] CNT_MAX = 16'd49_999
)
(
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [BIN_W-1:0]     data,
  input  logic                 sign,
  input  logic [DIGIT_NUM-1:0] point,
  input  logic                 load,
  input  logic                 seg_en,
  output logic                 busy,
  output logic [DIGIT_NUM-1:0] sel,
  output logic [7:0]           seg
);

  logic                 conv_busy;
  logic                 conv_done;
  logic [BCD_W-1:0]     conv_bcd;
  logic                 start;
  logic [BIN_W-1:0]     sat_bin;

  logic                 pend_neg_q;
  logic [DIGIT_NUM-1:0] pend_point_q;
  disp_t                disp_q;

  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DIGIT_NUM-1:0] sel_q, sel_d;
  logic [7:0]           seg_q, seg_d;

  logic [7:0]           pat [DIGIT_NUM];
  int                   top_nz;

  // A load while a conversion runs is dropped entirely, including sign/point.
  assign start   = load && !conv_busy;
  assign sat_bin = sat_value(data, sign);

  bin2bcd_seq u_bin2bcd (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (start),
    .bin   (sat_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend_neg_q   <= 1'b0;
      pend_point_q <= '0;
      disp_q       <= '0;
    end else begin
      if (start) begin
        pend_neg_q   <= sign;
        pend_point_q <= point;
      end
      if (conv_done) begin
        disp_q.bcd   <= conv_bcd;
        disp_q.neg   <= pend_neg_q;
        disp_q.point <= pend_point_q;
      end
    end
  end

  // Digit 0 is always shown; minus sits just left of the highest nonzero digit.
  always_comb begin
    top_nz = 0;
    for (int i = 1; i < DIGIT_NUM; i++) begin
      if (disp_q.bcd[4*i +: 4] != 4'd0) top_nz = i;
    end
    for (int i = 0; i < DIGIT_NUM; i++) begin
      if (i <= top_nz) begin
        pat[i] = digit_code(disp_q.bcd[4*i +: 4]);
      end else if (disp_q.neg && (i == top_nz + 1)) begin
        pat[i] = SEG_MINUS;
      end else begin
        pat[i] = SEG_BLANK;
      end
      if (disp_q.point[i]) pat[i][7] = 1'b0;
    end
  end

  // sel and seg both derive from the current idx so they switch together.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    sel_d = sel_q;
    seg_d = seg_q;
    if (!seg_en) begin
      cnt_d = '0;
      idx_d = '0;
      sel_d = '0;
      seg_d = SEG_BLANK;
    end else begin
      sel_d = {{(DIGIT_NUM-1){1'b0}}, 1'b1} << idx_q;
      seg_d = SEG_BLANK;
      for (int i = 0; i < DIGIT_NUM; i++) begin
        if (idx_q == 3'(i)) seg_d = pat[i];
      end
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = (idx_q == 3'(DIGIT_NUM - 1)) ? 3'd0 : idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      sel_q <= '0;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign busy = conv_busy;
  assign sel  = sel_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_seg_dynamic_ctrl.sv
// Directed and randomized bench for seg_dynamic_ctrl against an arithmetic display model.
module tb_seg_dynamic_ctrl;

  localparam logic [15:0] CNT_MAX = 16'd24;
  localparam int          DWELL   = 25;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [19:0] data;
  logic        sign;
  logic [5:0]  point;
  logic        load;
  logic        seg_en;
  logic        busy;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int tests = 0;
  int fails = 0;

  seg_dynamic_ctrl #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .sign    (sign),
    .point   (point),
    .load    (load),
    .seg_en  (seg_en),
    .busy    (busy),
    .sel     (sel),
    .seg     (seg)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Expected pattern of all six digits, digit i in bits [8i+7:8i].
  function automatic logic [47:0] model(input int unsigned d, input bit s, input logic [5:0] p);
    logic [7:0]  tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int unsigned v;
    int          dig [6];
    int          m;
    logic [7:0]  e;
    logic [47:0] r;
    v = d;
    if (s && v > 99999) v = 99999;
    if (!s && v > 999999) v = 999999;
    for (int i = 0; i < 6; i++) begin
      dig[i] = int'(v % 10);
      v = v / 10;
    end
    m = 0;
    for (int i = 0; i < 6; i++) if (dig[i] != 0) m = i;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      if (i <= m) e = tbl[dig[i]];
      else if (s && i == m + 1) e = 8'hBF;
      else e = 8'hFF;
      if (p[i]) e[7] = 1'b0;
      r[8*i +: 8] = e;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [19:0] d, input logic s, input logic [5:0] p,
                         output int nbusy);
    @(negedge sys_clk);
    data = d; sign = s; point = p; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      @(negedge sys_clk);
    end
  endtask

  task automatic check_disp(input logic [47:0] exp, input string tag);
    @(negedge sys_clk);
    for (int i = 0; i < 6; i++) begin
      int         w;
      logic [5:0] tgt;
      tgt = 6'(1) << i;
      w = 0;
      while (sel !== tgt && w < 400) begin
        @(negedge sys_clk);
        w++;
      end
      chk({tag, "_sel"}, 32'(sel), 32'(tgt));
      chk({tag, "_seg"}, 32'(seg), 32'(exp[8*i +: 8]));
    end
  endtask

  initial begin
    logic [47:0] e0;
    int          nb;
    int          slot;
    logic [19:0] rd;
    logic        rs;
    logic [5:0]  rp;

    sys_rst = 1'b1; seg_en = 1'b1; load = 1'b0;
    data = '0; sign = 1'b0; point = '0;
    e0 = model(0, 1'b0, 6'd0);

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_busy", 32'(busy), 32'h0);

    // Scan from reset: digit 0 first, 25 clocks per digit, wrap after six slots
    sys_rst = 1'b0;
    for (int k = 1; k <= 6 * DWELL + 1; k++) begin
      @(negedge sys_clk);
      slot = ((k - 1) / DWELL) % 6;
      chk("scan_sel", 32'(sel), 32'(1) << slot);
      chk("scan_seg", 32'(seg), 32'(e0[8*slot +: 8]));
    end

    // Basic conversion
    do_load(20'd123456, 1'b0, 6'd0, nb);
    chk("busy_len_123456", 32'(nb), 32'd20);
    check_disp(model(123456, 1'b0, 6'd0), "d123456");

    // Positive saturation
    do_load(20'd1000000, 1'b0, 6'd0, nb);
    chk("busy_len_sat", 32'(nb), 32'd20);
    check_disp(model(1000000, 1'b0, 6'd0), "sat_pos");

    // Negative with decimal point
    do_load(20'd42, 1'b1, 6'b000010, nb);
    check_disp(model(42, 1'b1, 6'b000010), "neg42");

    // Negative zero and negative saturation
    do_load(20'd0, 1'b1, 6'b100000, nb);
    check_disp(model(0, 1'b1, 6'b100000), "neg0");
    do_load(20'd500000, 1'b1, 6'd0, nb);
    check_disp(model(500000, 1'b1, 6'd0), "sat_neg");

    // Second load during busy is ignored
    @(negedge sys_clk);
    data = 20'd31415; sign = 1'b0; point = 6'd0; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    nb = 0;
    repeat (5) begin
      if (busy) nb++;
      @(negedge sys_clk);
    end
    data = 20'd777; sign = 1'b1; point = 6'b111111; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge sys_clk);
    end
    chk("busy_len_ignore", 32'(nb), 32'd19);
    check_disp(model(31415, 1'b0, 6'd0), "ignore");

    // Reset in the middle of a conversion
    @(negedge sys_clk);
    data = 20'd98765; sign = 1'b0; point = 6'b000001; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    repeat (9) @(negedge sys_clk);
    chk("busy_mid", 32'(busy), 32'h1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_sel", 32'(sel), 32'h0);
    chk("abort_seg", 32'(seg), 32'hFF);
    sys_rst = 1'b0;
    repeat (30) @(negedge sys_clk);
    chk("abort_busy_late", 32'(busy), 32'h0);
    check_disp(e0, "abort");

    // seg_en off mid-slot; conversion continues while dark
    while (sel !== 6'b000100) @(negedge sys_clk);
    repeat (5) @(negedge sys_clk);
    seg_en = 1'b0;
    @(negedge sys_clk);
    chk("off_sel", 32'(sel), 32'h0);
    chk("off_seg", 32'(seg), 32'hFF);
    do_load(20'd777, 1'b0, 6'd0, nb);
    chk("busy_len_dark", 32'(nb), 32'd20);
    chk("off_sel_hold", 32'(sel), 32'h0);
    seg_en = 1'b1;
    e0 = model(777, 1'b0, 6'd0);
    for (int k = 1; k <= DWELL + 1; k++) begin
      @(negedge sys_clk);
      slot = (k <= DWELL) ? 0 : 1;
      chk("on_sel", 32'(sel), 32'(1) << slot);
      chk("on_seg", 32'(seg), 32'(e0[8*slot +: 8]));
    end

    // Randomized values
    for (int r = 0; r < 6; r++) begin
      rd = (r % 2 == 1) ? 20'($urandom_range(0, 999)) : 20'($urandom_range(0, 20'hFFFFF));
      rs = 1'($urandom_range(0, 1));
      rp = 6'($urandom);
      do_load(rd, rs, rp, nb);
      chk("busy_len_rand", 32'(nb), 32'd20);
      check_disp(model(int'(rd), rs, rp), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
